// File: rtl/layer_sequencer_if.sv
// Control bundle between the top-level controller (master) and the layer
// sequencer (slave): run request, counts, DMA/filter completions and the
// sequencer's status pulses and indices.
interface layer_sequencer_if #(
    parameter int FILTER_W = 3,
    parameter int LAYER_W  = 3
);
    logic                start;
    logic [LAYER_W-1:0]  layersNumber;
    logic [FILTER_W-1:0] filtersNumber;
    logic                dmaFinish;
    logic                filterFinish;
    logic                loadConfig;
    logic                startFilterConv;
    logic                layerDone;
    logic                finish;
    logic                busy;
    logic [LAYER_W-1:0]  layerIndex;
    logic [FILTER_W-1:0] filterIndex;

    modport master (
        output start, layersNumber, filtersNumber, dmaFinish, filterFinish,
        input  loadConfig, startFilterConv, layerDone, finish, busy,
               layerIndex, filterIndex
    );

    modport slave (
        input  start, layersNumber, filtersNumber, dmaFinish, filterFinish,
        output loadConfig, startFilterConv, layerDone, finish, busy,
               layerIndex, filterIndex
    );
endinterface

// File: rtl/layer_sequencer.sv
// Multi-layer controller: for each layer request a configuration load, then
// pulse one start per filter and wait for its completion. Moore outputs only.
//
// Handshake: loadConfig is a level held for the whole LOAD state and the DMA
// answers with dmaFinish, which is honoured only in LOAD. startFilterConv is
// a one-cycle request and filterFinish, honoured only in CONV_WAIT, closes
// it. Completions seen in any other state are ignored.
module layer_sequencer #(
    parameter int FILTER_W = 3,
    parameter int LAYER_W  = 3
) (
    input  logic                    clk,
    input  logic                    resetState,
    layer_sequencer_if.slave        bus,
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_CONV_START = 3'd2,
        S_CONV_WAIT  = 3'd3,
        S_END_LAYER  = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [LAYER_W-1:0]  layer_total_q, layer_total_d;
    logic [LAYER_W-1:0]  layer_idx_q, layer_idx_d;
    logic [FILTER_W-1:0] filter_total_q, filter_total_d;
    logic [FILTER_W-1:0] filter_idx_q, filter_idx_d;

    // Last-index compares run against latched totals; the totals are
    // nonzero whenever these are consulted, so the minus one cannot wrap.
    logic last_filter;
    logic last_layer;
    assign last_filter = (filter_idx_q == filter_total_q - FILTER_W'(1));
    assign last_layer  = (layer_idx_q == layer_total_q - LAYER_W'(1));

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (resetState) begin
            state_q        <= S_IDLE;
            layer_total_q  <= '0;
            layer_idx_q    <= '0;
            filter_total_q <= '0;
            filter_idx_q   <= '0;
        end else begin
            state_q        <= state_d;
            layer_total_q  <= layer_total_d;
            layer_idx_q    <= layer_idx_d;
            filter_total_q <= filter_total_d;
            filter_idx_q   <= filter_idx_d;
        end
    end

    // Next state and counter updates.
    always_comb begin
        state_d        = state_q;
        layer_total_d  = layer_total_q;
        layer_idx_d    = layer_idx_q;
        filter_total_d = filter_total_q;
        filter_idx_d   = filter_idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    layer_total_d = bus.layersNumber;
                    layer_idx_d   = '0;
                    state_d       = (bus.layersNumber == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.dmaFinish) begin
                    filter_total_d = bus.filtersNumber;
                    filter_idx_d   = '0;
                    state_d = (bus.filtersNumber == '0) ? S_END_LAYER : S_CONV_START;
                end
            end
            S_CONV_START: begin
                state_d = S_CONV_WAIT;
            end
            S_CONV_WAIT: begin
                if (bus.filterFinish) begin
                    if (last_filter) begin
                        state_d = S_END_LAYER;
                    end else begin
                        filter_idx_d = filter_idx_q + FILTER_W'(1);
                        state_d      = S_CONV_START;
                    end
                end
            end
            S_END_LAYER: begin
                if (last_layer) begin
                    state_d = S_DONE;
                end else begin
                    layer_idx_d = layer_idx_q + LAYER_W'(1);
                    state_d     = S_LOAD;
                end
            end
            S_DONE: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state and counters.
    always_comb begin
        bus.loadConfig      = (state_q == S_LOAD);
        bus.startFilterConv = (state_q == S_CONV_START);
        bus.layerDone       = (state_q == S_END_LAYER);
        bus.finish          = (state_q == S_DONE);
        bus.busy            = (state_q != S_IDLE);
        bus.layerIndex      = layer_idx_q;
        bus.filterIndex     = filter_idx_q;
        state_dbg           = state_q;
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: default-width instance for the main
// scenarios and a 2-bit instance for all-ones counts.
module tb_layer_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_CS   = 3'd2;
    localparam logic [2:0] ST_CW   = 3'd3;
    localparam logic [2:0] ST_EL   = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer_sequencer_if #(.FILTER_W(3), .LAYER_W(3)) bus_a ();
    layer_sequencer_if #(.FILTER_W(2), .LAYER_W(2)) bus_b ();
    logic [2:0] dbg_a;
    logic [2:0] dbg_b;

    layer_sequencer #(.FILTER_W(3), .LAYER_W(3)) dut_a (
        .clk(clk), .resetState(rst), .bus(bus_a), .state_dbg(dbg_a)
    );
    layer_sequencer #(.FILTER_W(2), .LAYER_W(2)) dut_b (
        .clk(clk), .resetState(rst), .bus(bus_b), .state_dbg(dbg_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // scoreboard: expected filter indices at each startFilterConv pulse
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int pulse_a = 0;
    int done_a = 0;
    int pulse_b = 0;

    // pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus_a.startFilterConv === 1'b1) begin
            got_q.push_back(8'(bus_a.filterIndex));
            pulse_a <= pulse_a + 1;
        end
        if (bus_a.layerDone === 1'b1) done_a <= done_a + 1;
        if (bus_b.startFilterConv === 1'b1) pulse_b <= pulse_b + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run one layer on instance A from LOAD; gap = CONV_WAIT cycles before
    // filterFinish. filtersNumber is scrambled after latching.
    task automatic run_layer_a(input int nf, input int gap, input int li, input bit last);
        bus_a.filtersNumber = 3'(nf);
        bus_a.dmaFinish = 1'b1;
        tick();
        bus_a.dmaFinish = 1'b0;
        bus_a.filtersNumber = 3'($urandom_range(0, 7));
        if (nf == 0) chk("zero_filt_no_pulse", 32'(bus_a.startFilterConv), 0);
        for (int i = 0; i < nf; i++) begin
            chk("pulse", 32'(bus_a.startFilterConv), 1);
            chk("pulse_filter_idx", 32'(bus_a.filterIndex), i);
            chk("pulse_layer_idx", 32'(bus_a.layerIndex), li);
            exp_q.push_back(8'(i));
            repeat (gap) tick();
            chk("conv_wait", 32'(dbg_a), 32'(ST_CW));
            bus_a.filterFinish = 1'b1;
            tick();
            bus_a.filterFinish = 1'b0;
        end
        chk("layer_done", 32'(bus_a.layerDone), 1);
        chk("layer_done_idx", 32'(bus_a.layerIndex), li);
        tick();
        if (last) begin
            chk("finish", 32'(bus_a.finish), 1);
        end else begin
            chk("next_load", 32'(bus_a.loadConfig), 1);
            chk("next_layer_idx", 32'(bus_a.layerIndex), li + 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.layersNumber = '0; bus_a.filtersNumber = '0;
        bus_a.dmaFinish = 1'b0; bus_a.filterFinish = 1'b0;
        bus_b.start = 1'b0; bus_b.layersNumber = '0; bus_b.filtersNumber = '0;
        bus_b.dmaFinish = 1'b0; bus_b.filterFinish = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_state", 32'(dbg_a), 32'(ST_IDLE));
        chk("rst_busy", 32'(bus_a.busy), 0);
        chk("rst_finish", 32'(bus_a.finish), 0);
        chk("rst_load", 32'(bus_a.loadConfig), 0);

        // basic run: 2 layers x 3 filters, filterFinish 4 cycles after pulse
        bus_a.start = 1'b1;
        bus_a.layersNumber = 3'd2;
        tick();
        chk("basic_load", 32'(bus_a.loadConfig), 1);
        chk("basic_busy", 32'(bus_a.busy), 1);
        bus_a.layersNumber = 3'd0;
        run_layer_a(3, 4, 0, 1'b0);
        run_layer_a(3, 4, 1, 1'b1);
        repeat (3) tick();
        chk("hold_done", 32'(dbg_a), 32'(ST_DONE));
        chk("hold_finish", 32'(bus_a.finish), 1);
        bus_a.start = 1'b0;
        tick();
        chk("finish_drop", 32'(bus_a.finish), 0);
        chk("back_idle", 32'(dbg_a), 32'(ST_IDLE));
        chk("basic_pulses", 32'(pulse_a), 6);
        chk("basic_layer_dones", 32'(done_a), 2);
        chk("basic_sb_len", 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk("basic_sb_idx", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();

        // zero layers
        bus_a.start = 1'b1;
        bus_a.layersNumber = 3'd0;
        tick();
        chk("zero_layers_finish", 32'(bus_a.finish), 1);
        chk("zero_layers_noload", 32'(bus_a.loadConfig), 0);
        bus_a.start = 1'b0;
        tick();

        // zero filters on a single layer
        bus_a.start = 1'b1;
        bus_a.layersNumber = 3'd1;
        tick();
        chk("zf_load", 32'(bus_a.loadConfig), 1);
        run_layer_a(0, 1, 0, 1'b1);
        bus_a.start = 1'b0;
        tick();

        // stray completions in IDLE
        bus_a.dmaFinish = 1'b1;
        bus_a.filterFinish = 1'b1;
        tick();
        chk("stray_idle", 32'(dbg_a), 32'(ST_IDLE));
        chk("stray_idle_busy", 32'(bus_a.busy), 0);
        bus_a.dmaFinish = 1'b0;
        bus_a.filterFinish = 1'b0;

        // stray filterFinish/dmaFinish in CONV_START, then back-to-back
        bus_a.start = 1'b1;
        bus_a.layersNumber = 3'd2;
        tick();
        bus_a.filtersNumber = 3'd1;
        bus_a.dmaFinish = 1'b1;
        tick();
        chk("stray_cs_state", 32'(dbg_a), 32'(ST_CS));
        bus_a.filterFinish = 1'b1;
        tick();
        chk("stray_cs_ignored", 32'(dbg_a), 32'(ST_CW));
        bus_a.dmaFinish = 1'b0;
        tick();
        bus_a.filterFinish = 1'b0;
        chk("one_filter_done", 32'(bus_a.layerDone), 1);
        tick();
        chk("b2b_load", 32'(bus_a.loadConfig), 1);
        run_layer_a(3, 1, 1, 1'b1);
        bus_a.start = 1'b0;
        tick();

        // reset in CONV_WAIT of layer 1, then restart
        bus_a.start = 1'b1;
        bus_a.layersNumber = 3'd2;
        tick();
        run_layer_a(1, 2, 0, 1'b0);
        bus_a.filtersNumber = 3'd2;
        bus_a.dmaFinish = 1'b1;
        tick();
        bus_a.dmaFinish = 1'b0;
        tick();
        chk("pre_rst_cw", 32'(dbg_a), 32'(ST_CW));
        chk("pre_rst_layer", 32'(bus_a.layerIndex), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", 32'(dbg_a), 32'(ST_IDLE));
        chk("mid_rst_busy", 32'(bus_a.busy), 0);
        chk("mid_rst_layer_idx", 32'(bus_a.layerIndex), 0);
        chk("mid_rst_filter_idx", 32'(bus_a.filterIndex), 0);
        chk("mid_rst_outs", {27'd0, bus_a.loadConfig, bus_a.startFilterConv,
                             bus_a.layerDone, bus_a.finish, bus_a.busy}, 0);
        tick();
        chk("restart_load", 32'(bus_a.loadConfig), 1);
        chk("restart_layer", 32'(bus_a.layerIndex), 0);
        bus_a.start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // all-ones counts on the 2-bit instance, back-to-back filters
        bus_b.start = 1'b1;
        bus_b.layersNumber = 2'd3;
        tick();
        for (int l = 0; l < 3; l++) begin
            chk("max_load", 32'(bus_b.loadConfig), 1);
            bus_b.filtersNumber = 2'd3;
            bus_b.dmaFinish = 1'b1;
            tick();
            bus_b.dmaFinish = 1'b0;
            for (int f = 0; f < 3; f++) begin
                chk("max_pulse_idx", 32'(bus_b.filterIndex), f);
                tick();
                bus_b.filterFinish = 1'b1;
                tick();
                bus_b.filterFinish = 1'b0;
            end
            chk("max_layer_done", 32'(bus_b.layerDone), 1);
            chk("max_filter_no_wrap", 32'(bus_b.filterIndex), 3'd2);
            chk("max_layer_idx", 32'(bus_b.layerIndex), l);
            tick();
        end
        chk("max_finish", 32'(bus_b.finish), 1);
        chk("max_pulses", 32'(pulse_b), 9);
        bus_b.start = 1'b0;
        tick();
        chk("max_idle", 32'(dbg_b), 32'(ST_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
